friscv_apb_timer: RTL and testbench
===================================

FRISCV_APB_TIMER -- requirements
Module: friscv_apb_timer

Interface
REQ-001 SHALL have parameter ADDRW, default 16, request address width.
REQ-002 SHALL have parameter XLEN, default 32, data width; only 32 is supported.
REQ-003 SHALL have port aclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port areset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port slv_en  input  1  access request, held high until slv_ready is seen.
REQ-006 SHALL have port slv_wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have port slv_addr  input  ADDRW  register word index, relative to block base.
REQ-008 SHALL have port slv_wdata  input  XLEN  write data.
REQ-009 SHALL have port slv_strb  input  XLEN/8  byte write enables.
REQ-010 SHALL have port slv_rdata  output  XLEN  read data, valid while slv_ready=1.
REQ-011 SHALL have port slv_ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port timer_irq  output  1  machine timer interrupt, level.

Function
REQ-013 Register map by slv_addr: 0 CTRL, 1 MTIME_LO, 2 MTIME_HI, 3 MTIMECMP_LO, 4 MTIMECMP_HI, 5 STATUS.
REQ-014 CTRL: bit0 EN (count enable), bit1 IE (irq enable), bits[15:8] PRESC; other bits read 0.
REQ-015 STATUS: bit0 PEND, write-1-to-clear; other bits read 0.
REQ-016 Any other address: read returns 0, write ignored, access still completes with slv_ready.
REQ-017 FSM states IDLE, ACK, HOLD; reset state IDLE.
REQ-018 IDLE with slv_en=1: perform the access and register slv_ready=1 and slv_rdata; go to ACK. Latency = 1 cycle.
REQ-019 ACK: slv_ready=0, slv_rdata=0; go to IDLE if slv_en=0, else HOLD.
REQ-020 HOLD: stay until slv_en=0, then go to IDLE; no access is performed in ACK or HOLD.
REQ-021 slv_ready and slv_rdata are 0 outside the ACK-entry cycle.
REQ-022 Writes apply per byte lane for each slv_strb bit set; strb=0 writes nothing but still completes.
REQ-023 Prescaler: 8-bit counter; while EN=1, it increments every cycle.
REQ-024 When the prescaler equals PRESC, it clears to 0 and the 64-bit mtime increments once; PRESC=0 increments mtime every cycle.
REQ-025 EN=0 freezes mtime and holds the prescaler at 0.
REQ-026 mtime wraps from 0xFFFF_FFFF_FFFF_FFFF to 0; carry from LO to HI is applied in the same cycle.
REQ-027 A bus write to MTIME_LO/HI in the same cycle as an increment: the write wins for written bytes; the increment is dropped that cycle.
REQ-028 Compare: the unsigned test mtime >= mtimecmp is evaluated every cycle on the registered values; when true, PEND is set.
REQ-029 A W1C write to PEND while the compare is true leaves PEND=1; set wins.
REQ-030 timer_irq is registered PEND & IE, with one-cycle delay.
REQ-031 Reads return the current registered value; a read of MTIME_LO does not latch MTIME_HI.

Reset
REQ-032 On areset=1, all state clears immediately: FSM=IDLE, slv_ready=0, slv_rdata=0, timer_irq=0.
REQ-033 Reset values: CTRL=0, mtime=0, prescaler=0, PEND=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF.
REQ-034 Reset asserted mid-access aborts the access; after release, slv_en still high is treated as a new request in IDLE.

Verification
REQ-035 Write CTRL=0x0000_0003 (strb=0xF), then read CTRL -> slv_ready pulses 1 cycle after each slv_en rise; read data=0x0000_0003; no second ready while slv_en is held.
REQ-036 PRESC=3, EN=1, 40 cycles -> mtime advances 10 (+-1 at boundaries); PRESC=0 -> +1 per cycle.
REQ-037 mtime=0xFFFF_FFFF_FFFF_FFFE, EN=1, PRESC=0 -> reads show 0 after 2 cycles, with HI wrapped to 0.
REQ-038 mtimecmp=20, IE=1, EN=1 -> PEND sets when mtime=20, timer_irq high 1 cycle later; W1C PEND while mtime>=20 -> stays 1; mtimecmp=0xFFFF_FFFF then W1C -> timer_irq drops.
REQ-039 Read addr 7 -> 0 with ready; write MTIME_LO with strb=0x1, data 0xAB -> only byte0=0xAB.
REQ-040 Assert areset during HOLD with slv_en=1 -> outputs 0 immediately; after release, exactly one new ready pulse.

Source files
------------

// File: rtl/friscv_apb_timer.sv
// Machine timer (mtime/mtimecmp) with prescaler behind a simple request/ready
// register port. A pending compare match raises a level interrupt when enabled.
module friscv_apb_timer #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              slv_en,
  input  logic              slv_wr,
  input  logic [ADDRW-1:0]  slv_addr,
  input  logic [XLEN-1:0]   slv_wdata,
  input  logic [XLEN/8-1:0] slv_strb,
  output logic [XLEN-1:0]   slv_rdata,
  output logic              slv_ready,
  output logic              timer_irq
);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  localparam logic [ADDRW-1:0] A_CTRL   = ADDRW'(0);
  localparam logic [ADDRW-1:0] A_MT_LO  = ADDRW'(1);
  localparam logic [ADDRW-1:0] A_MT_HI  = ADDRW'(2);
  localparam logic [ADDRW-1:0] A_CMP_LO = ADDRW'(3);
  localparam logic [ADDRW-1:0] A_CMP_HI = ADDRW'(4);
  localparam logic [ADDRW-1:0] A_STATUS = ADDRW'(5);

  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]   old_v,
                                                  input logic [XLEN-1:0]   new_v,
                                                  input logic [XLEN/8-1:0] strb);
    logic [XLEN-1:0] r;
    r = old_v;
    for (int i = 0; i < XLEN/8; i++)
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            en_q, en_d, ie_q, ie_d;
  logic [7:0]      presc_q, presc_d;
  logic [7:0]      pcnt_q, pcnt_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     cmp_q, cmp_d;
  logic            pend_q, pend_d;
  logic            irq_q, irq_d;

  logic            do_acc, do_wr, tick, cmp_hit, mtime_wr;
  logic [XLEN-1:0] ctrl_word, ctrl_new, rd_val;

  always_comb begin
    do_acc    = (state_q == IDLE) && slv_en;
    do_wr     = do_acc && slv_wr;
    ctrl_word = {16'h0, presc_q, 6'h0, ie_q, en_q};
    ctrl_new  = merge_bytes(ctrl_word, slv_wdata, slv_strb);

    en_d    = en_q;
    ie_d    = ie_q;
    presc_d = presc_q;
    if (do_wr && slv_addr == A_CTRL) begin
      en_d    = ctrl_new[0];
      ie_d    = ctrl_new[1];
      presc_d = ctrl_new[15:8];
    end

    // Prescaler runs only while enabled; a match both clears it and ticks mtime.
    tick   = en_q && (pcnt_q == presc_q);
    pcnt_d = 8'h0;
    if (en_q && !tick) pcnt_d = pcnt_q + 8'd1;

    // A software write to either mtime half takes priority over the tick.
    mtime_wr = do_wr && (slv_addr == A_MT_LO || slv_addr == A_MT_HI) && (|slv_strb);
    mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
    if (mtime_wr) begin
      mtime_d = mtime_q;
      if (slv_addr == A_MT_LO) mtime_d[31:0]  = merge_bytes(mtime_q[31:0], slv_wdata, slv_strb);
      else                     mtime_d[63:32] = merge_bytes(mtime_q[63:32], slv_wdata, slv_strb);
    end

    cmp_d = cmp_q;
    if (do_wr && slv_addr == A_CMP_LO) cmp_d[31:0]  = merge_bytes(cmp_q[31:0], slv_wdata, slv_strb);
    if (do_wr && slv_addr == A_CMP_HI) cmp_d[63:32] = merge_bytes(cmp_q[63:32], slv_wdata, slv_strb);

    cmp_hit = (mtime_q >= cmp_q);
    pend_d  = pend_q;
    if (do_wr && slv_addr == A_STATUS && slv_strb[0] && slv_wdata[0]) pend_d = 1'b0;
    if (cmp_hit) pend_d = 1'b1;

    irq_d = pend_q & ie_q;

    case (slv_addr)
      A_CTRL:   rd_val = ctrl_word;
      A_MT_LO:  rd_val = mtime_q[31:0];
      A_MT_HI:  rd_val = mtime_q[63:32];
      A_CMP_LO: rd_val = cmp_q[31:0];
      A_CMP_HI: rd_val = cmp_q[63:32];
      A_STATUS: rd_val = {31'h0, pend_q};
      default:  rd_val = '0;
    endcase

    state_d = state_q;
    ready_d = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: if (slv_en) begin
        state_d = ACK;
        ready_d = 1'b1;
        rdata_d = slv_wr ? '0 : rd_val;
      end
      ACK:     state_d = slv_en ? HOLD : IDLE;
      HOLD:    if (!slv_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      presc_q <= 8'h0;
      pcnt_q  <= 8'h0;
      mtime_q <= 64'h0;
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
    end
  end

  assign slv_ready = ready_q;
  assign slv_rdata = rdata_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_friscv_apb_timer.sv
// Directed bench for friscv_apb_timer: stimulus pushes expected read data,
// a negedge monitor pops and compares on every ready pulse.
module tb_friscv_apb_timer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        slv_en, slv_wr;
  logic [15:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_strb;
  logic [31:0] slv_rdata;
  logic        slv_ready;
  logic        timer_irq;

  friscv_apb_timer #(.ADDRW(16), .XLEN(32)) dut (
    .aclk(aclk), .areset(areset), .slv_en(slv_en), .slv_wr(slv_wr),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_strb(slv_strb),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready), .timer_irq(timer_irq)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        chk;
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse consumes one scoreboard entry.
  always @(negedge aclk) begin
    exp_t e;
    if (slv_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: ready with rdata 0x%08h, expected no ready", slv_rdata);
      end else begin
        e = sbq.pop_front();
        if (e.chk) begin
          n_tests++;
          if (slv_rdata < e.lo || slv_rdata > e.hi) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h..0x%08h", e.name, slv_rdata, e.lo, e.hi);
          end
        end
      end
    end
  end

  task automatic bus(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, input logic [31:0] elo, input logic [31:0] ehi,
                     input string name, input int hold);
    exp_t e;
    int   cyc;
    e.chk = !wr; e.lo = elo; e.hi = ehi; e.name = name;
    sbq.push_back(e);
    @(posedge aclk); #1;
    slv_en = 1'b1; slv_wr = wr; slv_addr = addr; slv_wdata = wd; slv_strb = strb;
    cyc = 0;
    do begin
      @(posedge aclk); #1;
      cyc++;
    end while (!slv_ready && cyc < 8);
    check({name, "_latency"}, 32'(cyc), 32'd1);
    repeat (hold) @(posedge aclk);
    #1 slv_en = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] strb);
    bus(1'b1, addr, wd, strb, 32'h0, 32'h0, "wr", 0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
    bus(1'b0, addr, 32'h0, 4'h0, exp, exp, name, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   pulses;
    exp_t e;
    areset = 1'b1; slv_en = 1'b0; slv_wr = 1'b0; slv_addr = '0; slv_wdata = '0; slv_strb = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_ready", {31'h0, slv_ready}, 32'h0);
    check("rst_rdata", slv_rdata, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    areset = 1'b0;

    // Reset values
    rd(16'd0, 32'h0, "rst_ctrl");
    rd(16'd1, 32'h0, "rst_mtime_lo");
    rd(16'd2, 32'h0, "rst_mtime_hi");
    rd(16'd3, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(16'd4, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(16'd5, 32'h0, "rst_status");

    // CTRL write/read with slv_en held: one ready per request
    bus(1'b1, 16'd0, 32'h3, 4'hF, 32'h0, 32'h0, "ctrl_wr_hold", 3);
    bus(1'b0, 16'd0, 32'h0, 4'h0, 32'h3, 32'h3, "ctrl_rd_hold", 4);
    wr(16'd0, 32'hFFFF_FFFF, 4'hF);
    rd(16'd0, 32'h0000_FF03, "ctrl_mask");
    wr(16'd0, 32'h0, 4'hF);
    wr(16'd0, 32'h3, 4'h0);
    rd(16'd0, 32'h0, "ctrl_strb0");

    // Unmapped address and byte-lane writes
    rd(16'd7, 32'h0, "unmapped_rd");
    wr(16'd7, 32'h1234_5678, 4'hF);
    rd(16'd7, 32'h0, "unmapped_after_wr");
    wr(16'd1, 32'h1234_5678, 4'hF);
    wr(16'd1, 32'hFFFF_FFAB, 4'h1);
    rd(16'd1, 32'h1234_56AB, "mtime_lo_byte0");

    // PRESC=3: 42 enabled edges -> 10 ticks
    wr(16'd1, 32'h0, 4'hF);
    wr(16'd2, 32'h0, 4'hF);
    wr(16'd0, 32'h0301, 4'hF);
    repeat (40) @(posedge aclk);
    wr(16'd0, 32'h0, 4'hF);
    bus(1'b0, 16'd1, 32'h0, 4'h0, 32'd9, 32'd11, "presc3_count", 0);
    rd(16'd2, 32'h0, "presc3_hi");

    // PRESC=0: 10 enabled edges -> 10 ticks
    wr(16'd1, 32'h0, 4'hF);
    wr(16'd0, 32'h1, 4'hF);
    repeat (8) @(posedge aclk);
    wr(16'd0, 32'h0, 4'hF);
    rd(16'd1, 32'd10, "presc0_count");

    // 64-bit wrap: two enabled edges from ...FFFE
    wr(16'd1, 32'hFFFF_FFFE, 4'hF);
    wr(16'd2, 32'hFFFF_FFFF, 4'hF);
    wr(16'd0, 32'h1, 4'hF);
    wr(16'd0, 32'h0, 4'hF);
    rd(16'd1, 32'h0, "wrap_lo");
    rd(16'd2, 32'h0, "wrap_hi");

    // Compare / interrupt
    wr(16'd1, 32'h0, 4'hF);
    wr(16'd2, 32'h0, 4'hF);
    wr(16'd3, 32'd20, 4'hF);
    wr(16'd4, 32'h0, 4'hF);
    wr(16'd5, 32'h1, 4'h1);
    rd(16'd5, 32'h0, "pend_cleared");
    check("irq_idle", {31'h0, timer_irq}, 32'h0);
    wr(16'd0, 32'h3, 4'hF);
    cyc = 0;
    do begin
      @(posedge aclk); #1;
      cyc++;
    end while (!timer_irq && cyc < 100);
    check("irq_rise_cycles", 32'(cyc), 32'd22);
    wr(16'd5, 32'h1, 4'h1);
    rd(16'd5, 32'h1, "pend_set_wins");
    check("irq_held", {31'h0, timer_irq}, 32'h1);
    wr(16'd3, 32'hFFFF_FFFF, 4'hF);
    wr(16'd5, 32'h1, 4'h1);
    repeat (2) @(posedge aclk);
    #1 check("irq_dropped", {31'h0, timer_irq}, 32'h0);
    rd(16'd5, 32'h0, "pend_w1c");
    wr(16'd0, 32'h0, 4'hF);

    // Reset during HOLD with the interrupt active
    wr(16'd3, 32'h0, 4'hF);
    wr(16'd4, 32'h0, 4'hF);
    wr(16'd0, 32'h2, 4'hF);
    repeat (3) @(posedge aclk);
    #1 check("irq_before_rst", {31'h0, timer_irq}, 32'h1);
    e.chk = 1'b1; e.lo = 32'h2; e.hi = 32'h2; e.name = "hold_rd";
    sbq.push_back(e);
    @(posedge aclk); #1;
    slv_en = 1'b1; slv_wr = 1'b0; slv_addr = 16'd0; slv_strb = 4'h0;
    cyc = 0;
    do begin
      @(posedge aclk); #1;
      cyc++;
    end while (!slv_ready && cyc < 8);
    check("hold_rd_latency", 32'(cyc), 32'd1);
    repeat (2) @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    check("midrst_ready", {31'h0, slv_ready}, 32'h0);
    check("midrst_rdata", slv_rdata, 32'h0);
    check("midrst_irq", {31'h0, timer_irq}, 32'h0);
    e.chk = 1'b1; e.lo = 32'h0; e.hi = 32'h0; e.name = "post_rst_rd";
    sbq.push_back(e);
    @(posedge aclk); #1 areset = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge aclk);
      if (slv_ready) pulses++;
    end
    check("post_rst_pulses", 32'(pulses), 32'd1);
    #1 slv_en = 1'b0;
    repeat (3) @(posedge aclk);

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
